// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching engine: default geometry,
// controller state encoding and a constant log2 helper.
package sme_pkg;

  localparam int DEF_NUM_PE = 4;
  localparam int DEF_STR_AW = 8;
  localparam int DEF_PAT_AW = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REDUCE = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int log2c(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/min_idx_tree.sv
// Combinational pairwise argmin over N (valid, index) entries; returns the
// smallest valid index and its entry id, lower id winning ties.
module min_idx_tree #(
  parameter int N  = 4,
  parameter int IW = 8
) (
  input  logic [N-1:0]           valid_i,
  input  logic [N*IW-1:0]        idx_i,
  output logic                   valid_o,
  output logic [IW-1:0]          idx_o,
  output logic [$clog2(N)-1:0]   id_o
);

  localparam int IDW = $clog2(N);

  typedef struct packed {
    logic           v;
    logic [IW-1:0]  idx;
    logic [IDW-1:0] id;
  } node_t;

  // Left operand always carries the lower ids, so preferring it on equality
  // gives the lower-id tie-break.
  function automatic node_t pick(input node_t a, input node_t b);
    if (a.v && (!b.v || (a.idx <= b.idx))) return a;
    return b;
  endfunction

  // Heap layout: leaves at N-1..2N-2, node i combines 2i+1 and 2i+2.
  function automatic node_t reduce_tree(input logic [N-1:0] v,
                                        input logic [N*IW-1:0] ix);
    node_t nd [2*N-1];
    for (int j = 0; j < N; j++) begin
      nd[N-1+j].v   = v[j];
      nd[N-1+j].idx = ix[j*IW +: IW];
      nd[N-1+j].id  = IDW'(j);
    end
    for (int i = N-2; i >= 0; i--) begin
      nd[i] = pick(nd[2*i+1], nd[2*i+2]);
    end
    return nd[0];
  endfunction

  node_t root;

  always_comb begin
    root    = reduce_tree(valid_i, idx_i);
    valid_o = root.v;
    idx_o   = root.idx;
    id_o    = root.id;
  end

endmodule

// File: rtl/kmp_dispatch_ctrl.sv
// Job controller for the parallel matcher: partitions the string over the PE
// array, launches it, gathers per-PE results and returns the earliest match.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a job; lengths latched on accept
// ST_CALC   | segment bounds and PE mask computed and registered
// ST_LAUNCH | pe_start pulse high
// ST_WAIT   | collecting pe_done / pe_match from enabled PEs
// ST_REDUCE | argmin of captured matches registered into the result
// ST_RESP   | result held until res_ready
module kmp_dispatch_ctrl
  import sme_pkg::*;
#(
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int STR_AW = DEF_STR_AW,
  parameter int PAT_AW = DEF_PAT_AW
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       job_valid_i,
  output logic                       job_ready_o,
  input  logic [STR_AW-1:0]          str_last_idx_i,
  input  logic [PAT_AW-1:0]          pat_last_idx_i,
  input  logic                       abort_i,
  output logic                       pe_start_o,
  output logic [NUM_PE-1:0]          pe_en_o,
  output logic [NUM_PE*STR_AW-1:0]   start_idx_o,
  output logic [NUM_PE*STR_AW-1:0]   end_idx_o,
  input  logic [NUM_PE-1:0]          pe_done_i,
  input  logic [NUM_PE-1:0]          pe_match_i,
  input  logic [NUM_PE*STR_AW-1:0]   pe_match_idx_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic                       res_match_o,
  output logic [STR_AW-1:0]          res_match_idx_o,
  output logic [$clog2(NUM_PE)-1:0]  res_pe_o
);

  localparam int LOG2_PE = log2c(NUM_PE);
  localparam int IDW     = $clog2(NUM_PE);
  localparam int W       = STR_AW + 1;

  state_e state_q, state_d;

  logic [STR_AW-1:0]        str_q;
  logic [PAT_AW-1:0]        pat_q;
  logic [NUM_PE-1:0]        pe_en_q, pe_en_d;
  logic [NUM_PE*STR_AW-1:0] start_q, start_d;
  logic [NUM_PE*STR_AW-1:0] end_q, end_d;
  logic                     pe_start_q;
  logic [NUM_PE-1:0]        done_q;
  logic [NUM_PE-1:0]        match_q;
  logic [NUM_PE*STR_AW-1:0] midx_q;
  logic                     res_valid_q;
  logic                     res_match_q;
  logic [STR_AW-1:0]        res_idx_q;
  logic [IDW-1:0]           res_pe_q;

  logic              too_long;
  logic              abort_act;
  logic              all_done;
  logic [NUM_PE-1:0] done_now;
  logic [NUM_PE-1:0] cand_valid;
  logic              tree_v;
  logic [STR_AW-1:0] tree_idx;
  logic [IDW-1:0]    tree_id;

  logic [W-1:0] str_w, len_w, np_w, pat_w, s_w, e_w;

  assign too_long  = STR_AW'(pat_q) > str_q;
  assign abort_act = abort_i && (state_q != ST_IDLE);
  assign done_now  = done_q | (pe_done_i & pe_en_q);
  assign all_done  = (done_now & pe_en_q) == pe_en_q;

  // Widened by one bit so L = str_last_idx+1 and overlapped ends cannot wrap.
  always_comb begin
    str_w   = {1'b0, str_q};
    len_w   = str_w + W'(1);
    np_w    = len_w >> LOG2_PE;
    pat_w   = W'(pat_q);
    s_w     = '0;
    e_w     = '0;
    pe_en_d = '0;
    start_d = '0;
    end_d   = '0;
    if (!too_long) begin
      if (np_w == '0) begin
        pe_en_d                = NUM_PE'(1);
        end_d[STR_AW-1:0]      = str_q;
      end else begin
        pe_en_d = '1;
        for (int k = 0; k < NUM_PE; k++) begin
          s_w = W'(k) * np_w;
          e_w = W'(k + 1) * np_w - W'(1) + pat_w;
          if ((k == NUM_PE - 1) || (e_w > str_w)) e_w = str_w;
          start_d[k*STR_AW +: STR_AW] = s_w[STR_AW-1:0];
          end_d[k*STR_AW +: STR_AW]   = e_w[STR_AW-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (job_valid_i) state_d = ST_CALC;
      ST_CALC:   state_d = too_long ? ST_REDUCE : ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (all_done) state_d = ST_REDUCE;
      ST_REDUCE: state_d = ST_RESP;
      ST_RESP:   if (res_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort_act) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  assign cand_valid = done_q & match_q & pe_en_q;

  min_idx_tree #(
    .N  (NUM_PE),
    .IW (STR_AW)
  ) u_min_idx_tree (
    .valid_i (cand_valid),
    .idx_i   (midx_q),
    .valid_o (tree_v),
    .idx_o   (tree_idx),
    .id_o    (tree_id)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      str_q       <= '0;
      pat_q       <= '0;
      pe_en_q     <= '0;
      start_q     <= '0;
      end_q       <= '0;
      pe_start_q  <= 1'b0;
      done_q      <= '0;
      match_q     <= '0;
      midx_q      <= '0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_idx_q   <= '0;
      res_pe_q    <= '0;
    end else begin
      pe_start_q <= (state_q == ST_CALC) && !too_long && !abort_i;
      if (abort_act) begin
        pe_en_q     <= '0;
        start_q     <= '0;
        end_q       <= '0;
        done_q      <= '0;
        match_q     <= '0;
        res_valid_q <= 1'b0;
        res_match_q <= 1'b0;
        res_idx_q   <= '0;
        res_pe_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (job_valid_i) begin
              str_q   <= str_last_idx_i;
              pat_q   <= pat_last_idx_i;
              done_q  <= '0;
              match_q <= '0;
            end
          end
          ST_CALC: begin
            pe_en_q <= pe_en_d;
            start_q <= start_d;
            end_q   <= end_d;
          end
          ST_WAIT: begin
            for (int k = 0; k < NUM_PE; k++) begin
              if (pe_done_i[k] && pe_en_q[k]) begin
                done_q[k]                  <= 1'b1;
                match_q[k]                 <= pe_match_i[k];
                midx_q[k*STR_AW +: STR_AW] <= pe_match_idx_i[k*STR_AW +: STR_AW];
              end
            end
          end
          ST_REDUCE: begin
            res_valid_q <= 1'b1;
            res_match_q <= tree_v;
            res_idx_q   <= tree_v ? tree_idx : '0;
            res_pe_q    <= tree_v ? tree_id : '0;
          end
          ST_RESP: begin
            if (res_ready_i) res_valid_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign job_ready_o     = (state_q == ST_IDLE);
  assign pe_start_o      = pe_start_q;
  assign pe_en_o         = pe_en_q;
  assign start_idx_o     = start_q;
  assign end_idx_o       = end_q;
  assign res_valid_o     = res_valid_q;
  assign res_match_o     = res_match_q;
  assign res_match_idx_o = res_idx_q;
  assign res_pe_o        = res_pe_q;

endmodule

// File: doc/kmp_dispatch_ctrl.md
# kmp_dispatch_ctrl

- Parametrised job controller for the parallel string-matching engine.
- Accepts one match job per valid/ready handshake and splits the string into NUM_PE overlapping segments.
- Launches the PE array, collects per-PE done/match results, and reduces them to the earliest match index.
- Presents the result through a valid/ready output; successor to the fixed 4-PE controller, adding handshakes, abort and degenerate-length handling.

## Interface
- NUM_PE, 4: PE count; power of two, ≥2.
- STR_AW, 8: string index width.
- PAT_AW, 5: pattern index width; PAT_AW ≤ STR_AW.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- job_valid  in  1  job request.
- job_ready  out  1  high only in IDLE.
- str_last_idx  in  STR_AW  string length−1; sampled on accept.
- pat_last_idx  in  PAT_AW  pattern length−1 (segment overlap); sampled on accept.
- abort  in  1  synchronous cancel; highest priority after reset.
- pe_start  out  1  one-cycle launch pulse.
- pe_en  out  NUM_PE  enabled-PE mask.
- start_idx  out  NUM_PE*STR_AW  per-PE segment start, PE k at slice k.
- end_idx  out  NUM_PE*STR_AW  per-PE segment end, inclusive.
- pe_done  in  NUM_PE  per-PE one-cycle done pulse.
- pe_match  in  NUM_PE  per-PE match flag; valid with pe_done.
- pe_match_idx  in  NUM_PE*STR_AW  per-PE first match index; valid with pe_done.
- res_valid  out  1  result available.
- res_ready  in  1  result accepted.
- res_match  out  1  any PE matched.
- res_match_idx  out  STR_AW  earliest match index.
- res_pe  out  $clog2(NUM_PE)  winning PE.

## Operation
- States and transitions:
  - IDLE → CALC on job_valid && job_ready; latches both lengths.
  - CALC → LAUNCH.
  - LAUNCH → WAIT.
  - WAIT → REDUCE when every enabled PE has reported done.
  - REDUCE → RESP.
  - RESP → IDLE on res_valid && res_ready.
- Partition, with L = str_last_idx+1 and np = L >> log2(NUM_PE):
  - start_k = k*np.
  - end_k = min((k+1)*np−1+pat_last_idx, str_last_idx).
  - The last enabled PE always ends at str_last_idx, so it absorbs the remainder.
- All partition arithmetic is done at STR_AW+1 bits, then clipped; no wrap is permitted.
- np == 0: pe_en = 1 (PE0 only), start 0, end str_last_idx; all other slices are 0.
- pat_last_idx > str_last_idx: CALC → REDUCE directly. No pe_start is issued and the result is no-match.
- Otherwise pe_en is all ones.
- WAIT: a pe_done pulse sets a sticky done bit and captures pe_match/pe_match_idx for that PE.
  - Pulses from disabled PEs are ignored.
  - Pulses outside WAIT are ignored.
  - A repeated pulse overwrites the captured value.
- REDUCE: registered argmin over the captured indices of matching PEs. Equal indices go to the lower PE number.
- No match: res_match=0, res_match_idx=0, res_pe=0.
- abort in any non-IDLE state → IDLE next cycle.
  - Clears sticky bits, pe_en, start_idx, end_idx.
  - No pe_start or res_valid is produced for the aborted job.

## Timing
- Reset values: state IDLE, job_ready=1, pe_start=0, pe_en=0, start_idx=0, end_idx=0, res_valid=0, res_match=0, res_match_idx=0, res_pe=0.
- Job accepted at cycle A:
  - start_idx/end_idx/pe_en registered at the end of A+1.
  - pe_start=1 in A+2.
  - Indices stay stable from A+2 until return to IDLE.
- Last required pe_done in cycle D (may equal A+3) → REDUCE in D+1 → res_valid=1 from D+2.
- res_valid and the result fields hold until res_ready; the earliest next accept is the cycle after the handshake.
- Too-long pattern: res_valid from A+3.
- All outputs are registered (Moore), except job_ready, which is decoded from state.
- Reset asserted mid-job returns immediately to the reset values.

## Structure
- Shared package sme_pkg: default NUM_PE/STR_AW/PAT_AW, state encoding, log2 constant function.
- Sub-module min_idx_tree: parametrised pairwise argmin tree (valid, idx, PE id).
  - Invalid entries lose.
  - On ties the lower id wins.
  - Purely combinational; the controller registers its output in REDUCE.

## Test plan
- Divisible split: NUM_PE=4, str_last_idx=15, pat_last_idx=2.
  - Expect starts 0/4/8/12, ends 5/9/13/15, pe_en=1111.
  - Expect pe_start exactly in A+2.
- Remainder split: str_last_idx=17, pat_last_idx=3 → starts 0/4/8/12, ends 6/10/14/17.
- Degenerate:
  - str_last_idx=2 → pe_en=0001, start 0, end 2.
  - str_last_idx=3, pat_last_idx=5 → no pe_start; res_valid in A+3 with res_match=0.
- Reduction: PE1 done with match idx 6, PE3 with 13, PE0/PE2 with no match, pulses in different cycles.
  - Expect res_match=1, idx 6, res_pe=1, two cycles after the last done.
  - Tie variant: PE0 and PE2 both report 9 → res_pe=0.
- Backpressure: hold res_ready=0 for 3 cycles → result stable, job_ready=0, and a new job_valid is not accepted.
- Abort/reset:
  - abort in WAIT after PE0 done → IDLE next cycle, no res_valid, late pe_done ignored.
  - reset low mid-WAIT → all outputs at reset values immediately.
